fifo_to_mem_unpacker: RTL and testbench

Parametrised width-down converter between a standard-read-latency FIFO and a narrow on-chip memory write port. It is the generalised successor of the fixed 64→16-bit weight loader. Each FIFO word is split into `FIFO_WIDTH/MEM_WIDTH` lanes, and each lane is written to consecutive addresses starting at `BASE_ADDR`. Writes honour a memory-side ready signal for backpressure. The block stops after exactly `NUM_WORDS` writes, pulses `done`, and re-arms for the next load. It sits between the host DMA FIFO and the weight, bias or LUT memories of the accelerator.

---
 rtl/fifo_to_mem_unpacker.sv | 135 +++++++++++++
 tb/tb_fifo_to_mem_unpacker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_mem_unpacker.sv
// Splits each FIFO word into MEM_WIDTH lanes written to consecutive addresses.
// Ports: clk/rst_n, fifo_rd_data/fifo_empty/fifo_rd_en, mem_wr_*, flush, busy,
// done. Define UNPACK_MSB_FIRST_EN to emit the most-significant lane first.
module fifo_to_mem_unpacker #(
  parameter int unsigned FIFO_WIDTH = 64,
  parameter int unsigned MEM_WIDTH  = 16,
  parameter int unsigned NUM_WORDS  = 76323,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  mem_wr_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [MEM_WIDTH-1:0]  mem_wr_data,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned RATIO = FIFO_WIDTH / MEM_WIDTH;
  localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t state_q, state_d;

  logic                  fresh_q;
  logic [FIFO_WIDTH-1:0] word_q;
  logic [LANE_W-1:0]     lane_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  done_q;

  logic                  acc;
  logic                  last_lane;
  logic                  last_cnt;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] src;
  logic [MEM_WIDTH-1:0]  lane_data [RATIO];

  assign mem_wr_en = (state_q == WRITE);
  assign acc       = mem_wr_en & mem_wr_ready;
  assign last_lane = (lane_q == LAST_LANE);
  assign last_cnt  = (cnt_q == LAST_CNT);

  // Refill on the last-lane accept keeps writes back-to-back; no refill
  // when the final write is going out, so trailing lanes are dropped.
  assign rd_en = ~fifo_empty & ~flush &
                 ((state_q == IDLE) |
                  (acc & last_lane & ~last_cnt));

  assign fifo_rd_en = rd_en;

  // The word arrives one cycle after the read; use it directly that cycle
  // and from word_q afterwards so a stall sees identical data.
  assign src = fresh_q ? fifo_rd_data : word_q;

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
`ifdef UNPACK_MSB_FIRST_EN
    assign lane_data[k] = src[(RATIO-1-k)*MEM_WIDTH +: MEM_WIDTH];
`else
    assign lane_data[k] = src[k*MEM_WIDTH +: MEM_WIDTH];
`endif
  end

  always_comb begin
    mem_wr_data = '0;
    for (int k = 0; k < int'(RATIO); k++) begin
      if (lane_q == LANE_W'(k)) begin
        mem_wr_data = lane_data[k];
      end
    end
  end

  assign mem_wr_addr = BASE_ADDR + ADDR_WIDTH'(cnt_q);
  assign busy        = mem_wr_en | (cnt_q != '0);
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (rd_en) begin
        state_d = WRITE;
      end
    end else if (acc & (last_cnt | (last_lane & fifo_empty))) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fresh_q <= 1'b0;
      word_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= acc & last_cnt & ~flush;
      if (fresh_q) begin
        word_q <= fifo_rd_data;
      end
      if (flush) begin
        fresh_q <= 1'b0;
        lane_q  <= '0;
        cnt_q   <= '0;
      end else begin
        fresh_q <= rd_en;
        if (acc) begin
          if (last_cnt) begin
            cnt_q  <= '0;
            lane_q <= '0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            lane_q <= last_lane ? '0 : lane_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_to_mem_unpacker.sv
// Bench for fifo_to_mem_unpacker: u0 has 8 words per load at base 0,
// u1 has 6 words per load at base 0x100.
module tb_fifo_to_mem_unpacker;

  localparam logic [63:0] W1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] W2 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] W3 = 64'h000C_000B_000A_0009;

`ifdef UNPACK_MSB_FIRST_EN
  logic [15:0] es [8] = '{16'd4, 16'd3, 16'd2, 16'd1,
                          16'd8, 16'd7, 16'd6, 16'd5};
  logic [15:0] e3 = 16'h000C;
`else
  logic [15:0] es [8] = '{16'd1, 16'd2, 16'd3, 16'd4,
                          16'd5, 16'd6, 16'd7, 16'd8};
  logic [15:0] e3 = 16'h0009;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] rdd [2];
  logic [1:0]  empty;
  logic [1:0]  rd_en;
  logic [1:0]  rdy = 2'b11;
  logic [1:0]  wen;
  logic [1:0]  flush = 2'b00;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [31:0] addr0, addr1;
  logic [15:0] data0, data1;

  fifo_to_mem_unpacker #(
    .FIFO_WIDTH(64), .MEM_WIDTH(16), .NUM_WORDS(8),
    .ADDR_WIDTH(32), .BASE_ADDR(32'h0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .fifo_rd_data(rdd[0]), .fifo_empty(empty[0]),
    .fifo_rd_en(rd_en[0]), .mem_wr_ready(rdy[0]),
    .mem_wr_en(wen[0]), .mem_wr_addr(addr0),
    .mem_wr_data(data0), .flush(flush[0]),
    .busy(busy[0]), .done(done[0])
  );

  fifo_to_mem_unpacker #(
    .FIFO_WIDTH(64), .MEM_WIDTH(16), .NUM_WORDS(6),
    .ADDR_WIDTH(32), .BASE_ADDR(32'h100)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .fifo_rd_data(rdd[1]), .fifo_empty(empty[1]),
    .fifo_rd_en(rd_en[1]), .mem_wr_ready(rdy[1]),
    .mem_wr_en(wen[1]), .mem_wr_addr(addr1),
    .mem_wr_data(data1), .flush(flush[1]),
    .busy(busy[1]), .done(done[1])
  );

  // FIFO models: data valid only in the cycle after a read
  logic [63:0] fm [2][32];
  int wp [2] = '{default: 0};
  int rp [2] = '{default: 0};
  int rdc [2] = '{default: 0};
  int bad [2] = '{default: 0};

  always_comb begin
    for (int i = 0; i < 2; i++) empty[i] = (wp[i] == rp[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) begin
        rdd[i] <= fm[i][rp[i] % 32];
        rp[i]  <= rp[i] + 1;
        rdc[i] <= rdc[i] + 1;
        if (empty[i]) bad[i] <= bad[i] + 1;
      end else begin
        rdd[i] <= 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
  end

  // Write / done monitor
  logic [31:0] la [2][64];
  logic [15:0] ld [2][64];
  int lcyc [2][64];
  int lc [2] = '{default: 0};
  int dc [2] = '{default: 0};
  int dcyc [2] = '{default: 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wen[i] && rdy[i]) begin
        if (lc[i] < 64) begin
          la[i][lc[i]]   <= (i == 0) ? addr0 : addr1;
          ld[i][lc[i]]   <= (i == 0) ? data0 : data1;
          lcyc[i][lc[i]] <= cyc;
        end
        lc[i] <= lc[i] + 1;
      end
      if (done[i]) begin
        dc[i]   <= dc[i] + 1;
        dcyc[i] <= cyc;
      end
    end
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int s, logic [63:0] w);
    fm[s][wp[s] % 32] = w;
    wp[s] = wp[s] + 1;
  endtask

  task automatic wait_done(int s, int d0, int bound);
    int n;
    n = 0;
    while (dc[s] == d0 && n < bound) begin
      tick(1);
      n++;
    end
    chk("done_seen", 64'(dc[s] != d0), 1);
  endtask

  int b, b2, d, r, c0;

  initial begin
    // reset values
    tick(3);
    @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wen", wen, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_addr1", addr1, 32'h100);
    chk("rst_data0", data0, 0);
    chk("rst_data1", data1, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // full load of two words, back-to-back
    b = lc[0]; d = dc[0]; r = rdc[0];
    push(0, W1); push(0, W2);
    c0 = cyc;
    @(negedge clk);
    chk("t1_rd_en", rd_en[0], 1);
    wait_done(0, d, 40);
    tick(2);
    chk("t1_nwr", 64'(lc[0] - b), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_addr", la[0][b+i], 64'(i));
      chk("t1_data", ld[0][b+i], es[i]);
      chk("t1_cyc", 64'(lcyc[0][b+i]), 64'(c0 + 1 + i));
    end
    chk("t1_done_cyc", 64'(dcyc[0]), 64'(c0 + 9));
    chk("t1_ndone", 64'(dc[0] - d), 1);
    chk("t1_nrd", 64'(rdc[0] - r), 2);
    chk("t1_busy", busy[0], 0);

    // truncated load, then a new load from base
    b = lc[1]; d = dc[1]; r = rdc[1];
    push(1, W1); push(1, W2);
    wait_done(1, d, 40);
    tick(3);
    chk("t2_nwr", 64'(lc[1] - b), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_addr", la[1][b+i], 64'(32'h100 + i));
      chk("t2_data", ld[1][b+i], es[i]);
    end
    chk("t2_ndone", 64'(dc[1] - d), 1);
    chk("t2_nrd", 64'(rdc[1] - r), 2);
    chk("t2_busy", busy[1], 0);
    chk("t2_wen", wen[1], 0);
    b2 = lc[1];
    push(1, W3);
    tick(1);
    @(negedge clk);
    chk("t2_new_wen", wen[1], 1);
    chk("t2_new_addr", addr1, 32'h100);
    chk("t2_new_data", data1, e3);
    tick(6);
    chk("t2_new_nwr", 64'(lc[1] - b2), 4);
    chk("t2_gap_busy", busy[1], 1);
    chk("t2_no_done", 64'(dc[1] - d), 1);
    flush[1] = 1'b1;
    tick(1);
    flush[1] = 1'b0;
    @(negedge clk);
    chk("t2_flush_busy", busy[1], 0);
    tick(1);

    // backpressure at lane 0 of the second word
    b = lc[0]; d = dc[0]; r = rdc[0];
    push(0, W1); push(0, W2);
    c0 = cyc;
    tick(5);
    rdy[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rdy[0] = 1'b1;
      @(negedge clk);
      chk("t3_wen", wen[0], 1);
      chk("t3_addr", addr0, 4);
      chk("t3_data", data0, es[4]);
      tick(1);
    end
    wait_done(0, d, 40);
    tick(2);
    chk("t3_nwr", 64'(lc[0] - b), 8);
    chk("t3_a4_cyc", 64'(lcyc[0][b+4]), 64'(c0 + 8));
    chk("t3_a7_data", ld[0][b+7], es[7]);
    chk("t3_nrd", 64'(rdc[0] - r), 2);
    chk("t3_ndone", 64'(dc[0] - d), 1);

    // FIFO runs dry between words
    b = lc[0]; d = dc[0];
    push(0, W1);
    tick(5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_gap_wen", wen[0], 0);
      chk("t4_gap_busy", busy[0], 1);
      tick(1);
    end
    push(0, W2);
    tick(1);
    @(negedge clk);
    chk("t4_resume_wen", wen[0], 1);
    chk("t4_resume_addr", addr0, 4);
    chk("t4_resume_data", data0, es[4]);
    wait_done(0, d, 40);
    tick(2);
    chk("t4_nwr", 64'(lc[0] - b), 8);
    chk("t4_a7", la[0][b+7], 7);
    chk("t4_d7", ld[0][b+7], es[7]);

    // flush mid-load
    b = lc[0]; d = dc[0];
    push(0, W1); push(0, W2);
    tick(3);
    flush[0] = 1'b1;
    @(negedge clk);
    chk("t5_flush_addr", addr0, 2);
    tick(1);
    flush[0] = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy[0], 0);
    chk("t5_wen", wen[0], 0);
    tick(1);
    @(negedge clk);
    chk("t5_new_addr", addr0, 0);
    chk("t5_new_data", data0, es[4]);
    tick(6);
    chk("t5_ndone", 64'(dc[0] - d), 0);
    chk("t5_nwr", 64'(lc[0] - b), 7);
    chk("t5_gap_busy", busy[0], 1);
    flush[0] = 1'b1;
    tick(1);
    flush[0] = 1'b0;
    @(negedge clk);
    chk("t5_clean_busy", busy[0], 0);
    tick(1);

    // reset in the middle of a load
    push(0, W1);
    tick(2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_wen", wen[0], 0);
    chk("t6_addr", addr0, 0);
    chk("t6_data", data0, 0);
    chk("t6_busy", busy[0], 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    @(negedge clk);
    chk("t6_post_wen", wen[0], 0);
    chk("t6_post_busy", busy[0], 0);

    chk("rd_empty0", 64'(bad[0]), 0);
    chk("rd_empty1", 64'(bad[1]), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
